// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Four-requester round-robin arbiter for a shared 8-bit bus. A request seen at
// a rising edge is granted at that same edge; the owner keeps the bus while it
// holds its request. After MAX_TENURE granted cycles it may be preempted when
// another requester is waiting and lock is low. Every release (voluntary or
// preempted) is followed by one dead TURN cycle so two drivers never overlap.
//
// Parameters
//   MAX_TENURE : granted cycles before preemption becomes possible (2..15)
//
// Ports
//   clk     : in  - system clock, all state changes on the rising edge
//   clr     : in  - synchronous active-high reset, overrides everything
//   req     : in  - request bits, requester i holds req[i] for its tenure
//   lock    : in  - while high the current owner cannot be preempted
//   gnt     : out - registered grant, zero or one-hot
//   owner   : out - index of the granted requester, meaningful while busy
//   busy    : out - high exactly when gnt is non-zero
//   timeout : out - one-cycle pulse in the TURN cycle that follows a preemption
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int unsigned MAX_TENURE = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] req,
  input  logic       lock,
  output logic [3:0] gnt,
  output logic [1:0] owner,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_TENURE);

  state_t     state_q,   state_d;
  logic [3:0] gnt_q,     gnt_d;
  logic [1:0] owner_q,   owner_d;
  logic [1:0] ptr_q,     ptr_d;
  logic [3:0] cnt_q,     cnt_d;
  logic       timeout_q, timeout_d;

  // Round-robin candidates: slot k looks at requester (ptr + k) mod 4, so the
  // lowest hit slot is the first asserted request at or after the pointer.
  logic [1:0] cand_idx [4];
  logic [3:0] cand_hit;

  for (genvar gi = 0; gi < 4; gi++) begin : g_cand
    assign cand_idx[gi] = ptr_q + 2'(gi);
    assign cand_hit[gi] = req[cand_idx[gi]];
  end

  logic       found;
  logic [1:0] winner;

  always_comb begin
    found  = |req;
    winner = ptr_q;
    // Walk from the far slot down so the nearest hit wins.
    for (int k = 3; k >= 0; k--) begin
      if (cand_hit[k]) begin
        winner = cand_idx[k];
      end
    end
  end

  logic [3:0] owner_mask;
  logic       other_pending;
  logic       tenure_full;

  assign owner_mask    = 4'b0001 << owner_q;
  assign other_pending = |(req & ~owner_mask);
  assign tenure_full   = (cnt_q == MAX_CNT);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    case (state_q)
      // IDLE and TURN share the same arbitration at their closing edge; lock
      // plays no part here since nobody holds the bus.
      IDLE, TURN: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << winner;
          owner_d = winner;
          ptr_d   = winner + 2'd1;
          cnt_d   = 4'd1;
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          cnt_d   = 4'd0;
        end
      end

      GRANT: begin
        if (!req[owner_q]) begin
          // Owner finished on its own: release without a timeout pulse.
          state_d = TURN;
          gnt_d   = 4'b0000;
          cnt_d   = 4'd0;
        end else if (tenure_full && !lock && other_pending) begin
          state_d   = TURN;
          gnt_d     = 4'b0000;
          cnt_d     = 4'd0;
          timeout_d = 1'b1;
        end else if (!tenure_full) begin
          cnt_d = cnt_q + 4'd1;
        end
        // Otherwise the tenure is full but nothing may take the bus: the
        // counter sits at MAX_CNT and the grant is held.
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      owner_q   <= 2'd0;
      ptr_q     <= 2'd0;
      cnt_q     <= 4'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign busy    = |gnt_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed bench for bus_arbiter with MAX_TENURE = 8. Each scenario task drives
// its own stimulus and compares outputs one time unit after the rising edge.
// A negedge monitor checks that gnt is zero or one-hot and busy tracks it.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] req;
  logic       lock;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  bus_arbiter #(.MAX_TENURE(8)) dut (
    .clk     (clk),
    .clr     (clr),
    .req     (req),
    .lock    (lock),
    .gnt     (gnt),
    .owner   (owner),
    .busy    (busy),
    .timeout (timeout)
  );

  // Grant must be zero or one-hot every cycle, and busy must mirror it.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (!$onehot0(gnt) || (busy !== (|gnt))) begin
        errors++;
        $display("FAIL onehot_busy got gnt=%b busy=%b want onehot0 gnt and busy=|gnt", gnt, busy);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr  = 1'b1;
    req  = 4'b0000;
    lock = 1'b0;
    step();
    step();
    clr  = 1'b0;
  endtask

  task automatic test_reset();
    clr  = 1'b1;
    req  = 4'b1111;
    lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      mon_en = 1'b1;
      checks++;
      if ({gnt, owner, busy, timeout} !== 8'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d got gnt=%b owner=%0d busy=%b timeout=%b want all 0",
                 i, gnt, owner, busy, timeout);
      end
    end
    clr  = 1'b0;
    req  = 4'b0000;
    lock = 1'b0;
    step();
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle got gnt=%b want 0000", gnt);
    end
    $display("test_reset done");
  endtask

  // Request to grant latency, voluntary release, TURN gap, lock ignored in IDLE.
  task automatic test_basic();
    do_reset();
    lock = 1'b1;
    req  = 4'b0101;
    step();
    checks++;
    if (gnt !== 4'b0001 || owner !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_first got gnt=%b owner=%0d busy=%b want 0001 0 1", gnt, owner, busy);
    end
    req = 4'b0100;
    step();
    checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL basic_turn got gnt=%b timeout=%b want 0000 0", gnt, timeout);
    end
    step();
    checks++;
    if (gnt !== 4'b0100 || owner !== 2'd2) begin
      errors++;
      $display("FAIL basic_second got gnt=%b owner=%0d want 0100 2", gnt, owner);
    end
    req  = 4'b0000;
    lock = 1'b0;
    step();
    step();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle got gnt=%b busy=%b want 0000 0", gnt, busy);
    end
    $display("test_basic done");
  endtask

  // All four requesting: 8-cycle tenures, one TURN cycle with timeout between.
  task automatic test_rotation();
    logic [3:0] exp_g;
    do_reset();
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      exp_g = 4'b0001 << (r % 4);
      for (int c = 0; c < 8; c++) begin
        step();
        checks++;
        if (gnt !== exp_g || owner !== 2'(r % 4) || timeout !== 1'b0) begin
          errors++;
          $display("FAIL rot_tenure r%0d c%0d got gnt=%b owner=%0d timeout=%b want %b %0d 0",
                   r, c, gnt, owner, timeout, exp_g, r % 4);
        end
      end
      if (r < 4) begin
        step();
        checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b1) begin
          errors++;
          $display("FAIL rot_turn r%0d got gnt=%b timeout=%b want 0000 1", r, gnt, timeout);
        end
      end
    end
    req = 4'b0000;
    step();
    checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL rot_release got gnt=%b timeout=%b want 0000 0", gnt, timeout);
    end
    step();
    $display("test_rotation done");
  endtask

  // Lone requester keeps the bus past MAX_TENURE; preempted once another asks.
  task automatic test_preempt();
    do_reset();
    req = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if (gnt !== 4'b0010 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL preempt_hold c%0d got gnt=%b timeout=%b want 0010 0", c, gnt, timeout);
      end
    end
    req = 4'b1010;
    step();
    checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL preempt_turn got gnt=%b timeout=%b want 0000 1", gnt, timeout);
    end
    step();
    checks++;
    if (gnt !== 4'b1000 || owner !== 2'd3 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL preempt_next got gnt=%b owner=%0d timeout=%b want 1000 3 0", gnt, owner, timeout);
    end
    req = 4'b0000;
    step();
    step();
    $display("test_preempt done");
  endtask

  // Same as preemption but lock holds the owner until it drops its request.
  task automatic test_lock();
    do_reset();
    req = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      step();
    end
    lock = 1'b1;
    req  = 4'b1010;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (gnt !== 4'b0010 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL lock_hold c%0d got gnt=%b timeout=%b want 0010 0", c, gnt, timeout);
      end
    end
    req = 4'b1000;
    step();
    checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL lock_turn got gnt=%b timeout=%b want 0000 0", gnt, timeout);
    end
    step();
    checks++;
    if (gnt !== 4'b1000 || owner !== 2'd3) begin
      errors++;
      $display("FAIL lock_next got gnt=%b owner=%0d want 1000 3", gnt, owner);
    end
    lock = 1'b0;
    req  = 4'b0000;
    step();
    step();
    $display("test_lock done");
  endtask

  // clr mid-tenure and in TURN; pointer must restart at 0.
  task automatic test_clr_mid();
    do_reset();
    req = 4'b0100;
    step();
    step();
    step();
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL clr_pre got gnt=%b want 0100", gnt);
    end
    clr = 1'b1;
    step();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL clr_mid got gnt=%b busy=%b owner=%0d timeout=%b want 0000 0 0 0",
               gnt, busy, owner, timeout);
    end
    clr = 1'b0;
    req = 4'b1100;
    step();
    checks++;
    if (gnt !== 4'b0100 || owner !== 2'd2) begin
      errors++;
      $display("FAIL clr_regrant got gnt=%b owner=%0d want 0100 2", gnt, owner);
    end
    // Drop the owner's request to reach TURN, then clear during TURN.
    req = 4'b1000;
    step();
    clr = 1'b1;
    req = 4'b1111;
    step();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_turn got gnt=%b busy=%b want 0000 0", gnt, busy);
    end
    clr = 1'b0;
    step();
    checks++;
    if (gnt !== 4'b0001 || owner !== 2'd0) begin
      errors++;
      $display("FAIL clr_turn_regrant got gnt=%b owner=%0d want 0001 0", gnt, owner);
    end
    req = 4'b0000;
    step();
    step();
    $display("test_clr_mid done");
  endtask

  // A request pulse that never overlaps a rising edge is invisible.
  task automatic test_glitch();
    do_reset();
    #2 req = 4'b0001;
    #2 req = 4'b0000;
    step();
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL glitch_a got gnt=%b want 0000", gnt);
    end
    step();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_b got gnt=%b busy=%b want 0000 0", gnt, busy);
    end
    $display("test_glitch done");
  endtask

  initial begin
    clr  = 1'b1;
    req  = 4'b0000;
    lock = 1'b0;
    test_reset();
    test_basic();
    test_rotation();
    test_preempt();
    test_lock();
    test_clr_mid();
    test_glitch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_TENURE, default 8, giving the maximum granted cycles before preemption is allowed (legal range 2..15).
REQ-002 Port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 Port clr, input, 1 bit: reset; synchronous and active-high.
REQ-004 Port req, input, 4 bits: bus requests; bit i is held high by requester i for its whole desired tenure.
REQ-005 Port lock, input, 1 bit: when high, the current owner SHALL NOT be preempted.
REQ-006 Port gnt, output, 4 bits: registered one-hot grant; bit i high means requester i may drive the 8-bit bus.
REQ-007 Port owner, output, 2 bits: index of the granted requester; valid only while busy=1.
REQ-008 Port busy, output, 1 bit: high exactly when gnt is non-zero.
REQ-009 Port timeout, output, 1 bit: one-cycle pulse marking a preemption.

Function
REQ-010 gnt SHALL be zero or one-hot in every cycle; two bits high at once is an error.
REQ-011 The state machine SHALL have three states: IDLE, GRANT and TURN.
REQ-012 IDLE: gnt=0. If req is non-zero at a rising edge, the block SHALL go to GRANT with gnt set at that same edge (one-cycle request-to-grant latency).
REQ-013 Winner selection SHALL be round-robin: pick the first asserted req bit at or after pointer ptr, checking ptr, ptr+1, ... modulo 4.
REQ-014 On every grant, ptr SHALL become (winner+1) mod 4, and owner SHALL be set to the winner.
REQ-015 GRANT: a 4-bit tenure counter SHALL read 1 in the first granted cycle, increment each cycle, and saturate at MAX_TENURE.
REQ-016 GRANT: if req[owner]=0 at an edge, the block SHALL go to TURN and clear gnt at that edge.
REQ-017 GRANT: preemption SHALL occur when the counter equals MAX_TENURE, req[owner]=1, lock=0, and any other req bit is high.
REQ-018 On preemption, the block SHALL go to TURN, clear gnt, and pulse timeout high for exactly the first TURN cycle.
REQ-019 GRANT: if the counter is at MAX_TENURE and lock=1 or no other requester is pending, the grant SHALL be held indefinitely.
REQ-020 TURN SHALL last exactly one cycle with gnt=0 (bus turnaround, no contention); at its closing edge, selection per REQ-013 applies.
REQ-021 At the closing edge of TURN, the block SHALL go to GRANT if req is non-zero, else to IDLE.
REQ-022 The preempted requester SHALL be re-granted only through normal round-robin order; its req staying high is not a renewed priority.
REQ-023 Req bits that rise and fall between edges SHALL be ignored; only the values sampled at the edge count.
REQ-024 lock SHALL be ignored while no grant is held.

Reset
REQ-025 When clr=1 at a rising edge, the block SHALL set: state=IDLE, gnt=0, owner=0, busy=0, timeout=0, counter=0, ptr=0.
REQ-026 clr SHALL take priority over every other event, including mid-tenure and in TURN; gnt SHALL be 0 in the cycle after the clr edge.
REQ-027 While clr is held high, all outputs SHALL stay at their reset values regardless of req.

Verification
REQ-028 After reset, set req=4'b0101 -> next edge gnt=0001, owner=0, busy=1; drop req[0] -> gnt=0 for one TURN cycle, then gnt=0100, owner=2.
REQ-029 Hold req=4'b1111 continuously with MAX_TENURE=8 and lock=0 -> grants rotate 0,1,2,3,0; each tenure is 8 cycles followed by 1 cycle with gnt=0; timeout pulses once per rotation step.
REQ-030 Requester 1 granted alone, held 20 cycles, lock=0 -> gnt=0010 throughout with no timeout; raise req[3] at cycle 20 -> next edge TURN with timeout=1, following edge gnt=1000.
REQ-031 Same as REQ-030 but lock=1 when req[3] rises -> gnt stays 0010 and timeout stays 0 until req[1] drops; then one TURN cycle, then gnt=1000.
REQ-032 Assert clr mid-tenure (gnt=0100) -> next cycle gnt=0, busy=0, ptr=0; release clr with req=4'b1100 -> gnt=0100 one edge later.
REQ-033 Apply a req pulse shorter than one clock period between edges in IDLE -> gnt stays 0; check one-hot/zero gnt in every cycle with an assertion.
